ahb_to_axi4lite_bridge: RTL and testbench

Converts single AHB-Lite transfers into AXI4-Lite read/write transactions and returns the AXI4-Lite response to AHB. Sits directly downstream of the AHB master multicycle stage and consumes its ahb_mst_* bus. One transfer is in flight at a time. Bursts are carried as back-to-back single transfers.

---
 rtl/ahb_to_axi4lite_bridge.sv | 135 +++++++++++++
 tb/tb_ahb_to_axi4lite_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_to_axi4lite_bridge.sv
// rtl/ahb_to_axi4lite_bridge.sv - AHB-Lite single-transfer to AXI4-Lite bridge
module ahb_to_axi4lite_bridge (
  input  logic        hclk,
  input  logic        reset,
  input  logic [31:0] ahb_slv_haddr,
  input  logic [1:0]  ahb_slv_htrans,
  input  logic        ahb_slv_hwrite,
  input  logic [2:0]  ahb_slv_hsize,
  input  logic [31:0] ahb_slv_hwdata,
  output logic [31:0] ahb_slv_hrdata,
  output logic        ahb_slv_hready,
  output logic [1:0]  ahb_slv_hresp,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WDATA, WRITE, WRESP, READ, RRESP, ERR1, ERR2
  } state_t;

  state_t     state, state_d;
  logic       aw_done, w_done, aw_done_d, w_done_d;
  logic       aw_done_n, w_done_n;
  logic       accept;
  logic [3:0] strb;

  // Only the SLVERR/DECERR bit of the AXI response matters to AHB.
  logic unused_resp_bits;
  assign unused_resp_bits = axi_bresp[0] ^ axi_rresp[0];

  always_comb begin
    strb = 4'b1111;
    case (ahb_slv_hsize)
      3'd0:    strb = 4'b0001 << ahb_slv_haddr[1:0];
      3'd1:    strb = 4'b0011 << {ahb_slv_haddr[1], 1'b0};
      default: strb = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    accept    = ((state == IDLE) || (state == ERR2)) && ahb_slv_htrans[1];
    aw_done_n = aw_done | (axi_awvalid & axi_awready);
    w_done_n  = w_done | (axi_wvalid & axi_wready);
    case (state)
      IDLE, ERR2: begin
        if (!accept)                    state_d = IDLE;
        else if (ahb_slv_hsize > 3'd2)  state_d = ERR1;
        else if (ahb_slv_hwrite)        state_d = WDATA;
        else                            state_d = READ;
      end
      WDATA: begin
        state_d   = WRITE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      WRITE: begin
        aw_done_d = aw_done_n;
        w_done_d  = w_done_n;
        if (aw_done_n && w_done_n) begin
          state_d   = WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP:   if (axi_bvalid)  state_d = axi_bresp[1] ? ERR1 : IDLE;
      READ:    if (axi_arready) state_d = RRESP;
      RRESP:   if (axi_rvalid)  state_d = axi_rresp[1] ? ERR1 : IDLE;
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge hclk) begin
    if (reset) begin
      state          <= IDLE;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      ahb_slv_hready <= 1'b1;
      ahb_slv_hresp  <= 2'b00;
      ahb_slv_hrdata <= '0;
      axi_awaddr     <= '0;
      axi_awvalid    <= 1'b0;
      axi_wdata      <= '0;
      axi_wstrb      <= '0;
      axi_wvalid     <= 1'b0;
      axi_bready     <= 1'b0;
      axi_araddr     <= '0;
      axi_arvalid    <= 1'b0;
      axi_rready     <= 1'b0;
    end else begin
      state          <= state_d;
      aw_done        <= aw_done_d;
      w_done         <= w_done_d;
      ahb_slv_hready <= (state_d == IDLE) || (state_d == ERR2);
      ahb_slv_hresp  <= ((state_d == ERR1) || (state_d == ERR2)) ? 2'b01 : 2'b00;
      axi_awvalid    <= (state_d == WRITE) && !aw_done_d;
      axi_wvalid     <= (state_d == WRITE) && !w_done_d;
      axi_bready     <= (state_d == WRESP);
      axi_arvalid    <= (state_d == READ);
      axi_rready     <= (state_d == RRESP);
      if (accept && (ahb_slv_hsize <= 3'd2)) begin
        if (ahb_slv_hwrite) begin
          axi_awaddr <= ahb_slv_haddr;
          axi_wstrb  <= strb;
        end else begin
          axi_araddr <= ahb_slv_haddr;
        end
      end
      if (state == WDATA)
        axi_wdata <= ahb_slv_hwdata;
      if ((state == RRESP) && axi_rvalid)
        ahb_slv_hrdata <= axi_rdata;
    end
  end

endmodule

// File: tb/tb_ahb_to_axi4lite_bridge.sv
// tb/tb_ahb_to_axi4lite_bridge.sv - directed and randomized bench for the AHB to AXI4-Lite bridge
module tb_ahb_to_axi4lite_bridge;

  logic        hclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  logic [31:0] m_rdata = '0;

  ahb_to_axi4lite_bridge dut (
    .hclk(hclk), .reset(reset),
    .ahb_slv_haddr(haddr), .ahb_slv_htrans(htrans), .ahb_slv_hwrite(hwrite),
    .ahb_slv_hsize(hsize), .ahb_slv_hwdata(hwdata), .ahb_slv_hrdata(hrdata),
    .ahb_slv_hready(hready), .ahb_slv_hresp(hresp),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready)
  );

  always #5 hclk = ~hclk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge hclk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Enabled lanes are the naturally aligned group of 2**size bytes containing the address.
  function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [2:0] s);
    int n, base;
    logic [3:0] r;
    n = 1 << s;
    base = (int'(a[1:0]) / n) * n;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= base) && (i < base + n);
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic err_tail(input string tag);
    check({tag, "_err1_hready"}, hready, 0);
    check({tag, "_err1_hresp"}, hresp, 2'b01);
    tick();
    check({tag, "_err2_hready"}, hready, 1);
    check({tag, "_err2_hresp"}, hresp, 2'b01);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                          input int awd, input int wd, input int bd, input logic [1:0] br,
                          input string tag);
    int t0, k, awc, wcnt, bh;
    check({tag, "_start_hready"}, hready, 1);
    haddr = a; htrans = 2'b10; hwrite = 1'b1; hsize = s; t0 = cyc;
    tick();
    htrans = 2'b00; hwdata = d;
    check({tag, "_t1_hready"}, hready, 0);
    tick();
    check({tag, "_awaddr"}, awaddr, a);
    check({tag, "_wdata"}, wdata, d);
    check({tag, "_wstrb"}, wstrb, exp_strb(a, s));
    k = 0; awc = 0; wcnt = 0;
    while (!bready && k < 40) begin
      if (awvalid) awc++;
      if (wvalid) wcnt++;
      awready = (k >= awd);
      wready = (k >= wd);
      tick();
      k++;
    end
    awready = 1'b0; wready = 1'b0;
    check({tag, "_awvalid_cycles"}, awc, awd + 1);
    check({tag, "_wvalid_cycles"}, wcnt, wd + 1);
    k = 0; bh = 0;
    while (bready && k < 40) begin
      bvalid = (k >= bd);
      bresp = br;
      if (bvalid) bh++;
      tick();
      k++;
    end
    bvalid = 1'b0;
    check({tag, "_b_handshakes"}, bh, 1);
    check({tag, "_hrdata_hold"}, hrdata, m_rdata);
    if (br[1]) err_tail(tag);
    else begin
      check({tag, "_done_hready"}, hready, 1);
      check({tag, "_done_hresp"}, hresp, 2'b00);
      check({tag, "_latency"}, cyc - t0, 2 + (max2(awd, wd) + 1) + (bd + 1));
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] s, input logic [31:0] rd,
                         input int ard, input int rdd, input logic [1:0] rr, input string tag);
    int t0, k, arc, rh;
    check({tag, "_start_hready"}, hready, 1);
    haddr = a; htrans = 2'b10; hwrite = 1'b0; hsize = s; t0 = cyc;
    tick();
    htrans = 2'b00;
    check({tag, "_t1_hready"}, hready, 0);
    check({tag, "_araddr"}, araddr, a);
    k = 0; arc = 0;
    while (arvalid && k < 40) begin
      arc++;
      arready = (k >= ard);
      tick();
      k++;
    end
    arready = 1'b0;
    check({tag, "_arvalid_cycles"}, arc, ard + 1);
    check({tag, "_rready"}, rready, 1);
    k = 0; rh = 0;
    while (rready && k < 40) begin
      rvalid = (k >= rdd);
      rdata = rd;
      rresp = rr;
      if (rvalid) rh++;
      tick();
      k++;
    end
    rvalid = 1'b0;
    m_rdata = rd;
    check({tag, "_r_handshakes"}, rh, 1);
    check({tag, "_hrdata"}, hrdata, m_rdata);
    if (rr[1]) err_tail(tag);
    else begin
      check({tag, "_done_hready"}, hready, 1);
      check({tag, "_done_hresp"}, hresp, 2'b00);
      check({tag, "_latency"}, cyc - t0, 1 + (ard + 1) + (rdd + 1));
    end
  endtask

  task automatic do_bad(input logic [31:0] a, input logic w, input string tag);
    check({tag, "_start_hready"}, hready, 1);
    haddr = a; htrans = 2'b11; hwrite = w; hsize = 3'($urandom_range(3, 7));
    tick();
    htrans = 2'b00;
    check({tag, "_valids1"}, {awvalid, wvalid, arvalid}, 3'b000);
    check({tag, "_err1_hready"}, hready, 0);
    check({tag, "_err1_hresp"}, hresp, 2'b01);
    tick();
    check({tag, "_valids2"}, {awvalid, wvalid, arvalid}, 3'b000);
    check({tag, "_err2_hready"}, hready, 1);
    check({tag, "_err2_hresp"}, hresp, 2'b01);
  endtask

  task automatic idle_step(input string tag);
    htrans = 2'b01;
    tick();
    htrans = 2'b00;
    check({tag, "_idle_hready"}, hready, 1);
    check({tag, "_idle_hresp"}, hresp, 2'b00);
  endtask

  initial begin
    int op, sz, d1, d2;
    logic [1:0] resp;
    reset = 1'b1;
    tick();
    tick();
    check("rst_hready", hready, 1);
    check("rst_hresp", hresp, 2'b00);
    check("rst_hrdata", hrdata, 0);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("rst_awaddr", awaddr, 0);
    check("rst_araddr", araddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    reset = 1'b0;

    do_write(32'h1000_0004, 3'd2, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, "word_wr");
    do_write(32'h2000_0003, 3'd0, 32'hA5A5_5A5A, 0, 3, 1, 2'b00, "stall_wr");
    do_write(32'h2000_0006, 3'd1, 32'h0102_0304, 2, 1, 0, 2'b01, "half_wr");
    do_read(32'h3000_0010, 3'd2, 32'h1234_5678, 2, 0, 2'b00, "word_rd");
    do_write(32'h4000_0000, 3'd2, 32'h0BAD_F00D, 1, 0, 2, 2'b10, "slverr_wr");
    do_read(32'h4000_0008, 3'd2, 32'hCAFE_0001, 0, 1, 2'b11, "err2_rd");
    do_write(32'h4000_0001, 3'd0, 32'h0000_00EE, 0, 0, 0, 2'b00, "err2_wr");
    idle_step("post_err");
    do_bad(32'h5000_0000, 1'b1, "bad_wr");
    idle_step("post_bad");
    do_bad(32'h5000_0004, 1'b0, "bad_rd");
    do_read(32'h5000_0008, 3'd0, 32'h7777_8888, 0, 0, 2'b00, "after_bad_rd");

    haddr = 32'h6000_0000; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    tick();
    htrans = 2'b00; hwdata = 32'h1111_2222;
    tick();
    check("midrst_awvalid_before", awvalid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_rdata = '0;
    check("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("midrst_hready", hready, 1);
    check("midrst_hresp", hresp, 2'b00);
    check("midrst_hrdata", hrdata, m_rdata);
    do_write(32'h6000_0008, 3'd2, 32'h3333_4444, 0, 0, 0, 2'b00, "midrst_next_wr");

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 5);
      sz = $urandom_range(0, 2);
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if (op <= 2)
        do_write($urandom, 3'(sz), $urandom, d1, d2, $urandom_range(0, 2), resp, "rnd_wr");
      else if (op <= 4)
        do_read($urandom, 3'(sz), $urandom, d1, d2, resp, "rnd_rd");
      else
        do_bad($urandom, 1'($urandom_range(0, 1)), "rnd_bad");
    end
    idle_step("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
